hkspi_responder: RTL and testbench

//  Housekeeping SPI responder (SPI mode 0, MSB first), oversampled in the system clock domain.

---
 rtl/hkspi_pkg.sv | 30 +++
 rtl/hkspi_sync_edge.sv | 51 +++++
 rtl/hkspi_responder.sv | 154 +++++++++++++++
 tb/tb_hkspi_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hkspi_pkg: shared state and command encodings for the HK SPI slave   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hkspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMMAND = 3'd1,
    ST_ADDRESS = 3'd2,
    ST_DATA    = 3'd3,
    ST_IGNORE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RDWR  = 2'b11;

  function automatic logic cmd_reads(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_RDWR);
  endfunction

  function automatic logic cmd_writes(input logic [1:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_RDWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hkspi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hkspi_sync_edge: pad synchronizers, SCK edge pulses, fill indicator  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hkspi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic csb_i,
  input  logic sdi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_o,
  output logic sdi_o,
  output logic valid_o
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] csb_q;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sck_last_q;

  // fill_q marks when the chains hold real pad samples rather than reset values
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q      <= '0;
      csb_q      <= '1;
      sdi_q      <= '0;
      fill_q     <= '0;
      sck_last_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      csb_q      <= {csb_q[SYNC_STAGES-2:0], csb_i};
      sdi_q      <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_last_q <= sck_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_last_q;
  assign sck_fall_o = ~sck_q[SYNC_STAGES-1] & sck_last_q;
  assign csb_o      = csb_q[SYNC_STAGES-1];
  assign sdi_o      = sdi_q[SYNC_STAGES-1];
  assign valid_o    = fill_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/hkspi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hkspi_responder: housekeeping SPI responder, mode 0, oversampled     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_csb_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              spi_sdo_oe_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              busy_o
);

  logic sck_rise, sck_fall, csb, sdi, sync_valid;

  hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .sck_i      (spi_sck_i),
    .csb_i      (spi_csb_i),
    .sdi_i      (spi_sdi_i),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .csb_o      (csb),
    .sdi_o      (sdi),
    .valid_o    (sync_valid)
  );

  state_t            state_q;
  logic [2:0]        bit_cnt_q, byte_cnt_q, n_q;
  logic [6:0]        shin_q;
  logic [7:0]        shout_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q, wr_q, we_q, re_q, sdo_q, oe_q;
  logic              armed_q, inc_pend_q, prefetch_q, rd_pend_q;
  logic [7:0]        byte_d;

  assign byte_d = {shin_q, sdi};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      n_q        <= '0;
      shin_q     <= '0;
      shout_q    <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      sdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      armed_q    <= 1'b0;
      inc_pend_q <= 1'b0;
      prefetch_q <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_pend_q <= re_q;
      if (rd_pend_q) shout_q <= reg_rdata_i;
      // Increment runs one clk after the write strobe; the read of the new address follows
      if (inc_pend_q) begin
        inc_pend_q <= 1'b0;
        addr_q     <= addr_q + ADDR_W'(1);
        re_q       <= prefetch_q;
      end
      if (csb) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        sdo_q     <= 1'b0;
        oe_q      <= 1'b0;
        if (sync_valid) armed_q <= 1'b1;
      end else if (state_q == ST_IDLE) begin
        // Only a CSB fall observed after reset starts a transfer
        if (armed_q) begin
          state_q    <= ST_COMMAND;
          armed_q    <= 1'b0;
          bit_cnt_q  <= '0;
          byte_cnt_q <= '0;
        end
      end else begin
        if (sck_fall && state_q == ST_DATA && rd_q) begin
          sdo_q   <= shout_q[7];
          shout_q <= {shout_q[6:0], 1'b0};
        end
        if (sck_rise && state_q != ST_IGNORE) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          shin_q    <= byte_d[6:0];
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              ST_COMMAND: begin
                if (byte_d[7:6] == CMD_NOP) begin
                  state_q <= ST_IGNORE;
                end else begin
                  state_q <= ST_ADDRESS;
                  rd_q    <= cmd_reads(byte_d[7:6]);
                  wr_q    <= cmd_writes(byte_d[7:6]);
                  n_q     <= byte_d[5:3];
                end
              end
              ST_ADDRESS: begin
                state_q <= ST_DATA;
                addr_q  <= ADDR_W'(byte_d);
                re_q    <= rd_q;
                oe_q    <= rd_q;
              end
              ST_DATA: begin
                we_q       <= wr_q;
                wdata_q    <= byte_d;
                inc_pend_q <= 1'b1;
                byte_cnt_q <= byte_cnt_q + 3'd1;
                if (n_q != 3'd0 && (byte_cnt_q + 3'd1) == n_q) begin
                  state_q    <= ST_IGNORE;
                  oe_q       <= 1'b0;
                  prefetch_q <= 1'b0;
                end else begin
                  prefetch_q <= rd_q;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign spi_sdo_o    = sdo_q;
  assign spi_sdo_oe_o = oe_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_we_o     = we_q;
  assign reg_re_o     = re_q;
  assign busy_o       = ~csb;

endmodule
`default_nettype wire

// File: tb/tb_hkspi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hkspi_responder: directed SPI transfers against hkspi_responder   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hkspi_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck_i, spi_csb_i, spi_sdi_i;
  logic       spi_sdo_o, spi_sdo_oe_o;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_we_o, reg_re_o, busy_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] ra_q[$];
  logic       both_seen = 1'b0;

  always #5 clk = ~clk;

  hkspi_responder #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .spi_sck_i    (spi_sck_i),
    .spi_csb_i    (spi_csb_i),
    .spi_sdi_i    (spi_sdi_i),
    .spi_sdo_o    (spi_sdo_o),
    .spi_sdo_oe_o (spi_sdo_oe_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_we_o     (reg_we_o),
    .reg_re_o     (reg_re_o),
    .reg_rdata_i  (reg_rdata_i),
    .busy_o       (busy_o)
  );

  // Register file model: read data appears the clock after the read strobe
  always @(posedge clk) begin
    if (reg_re_o) reg_rdata_i <= mem[reg_addr_o];
    if (reg_we_o) mem[reg_addr_o] <= reg_wdata_o;
  end

  always @(negedge clk) begin
    if (reg_we_o) begin wa_q.push_back(reg_addr_o); wd_q.push_back(reg_wdata_o); end
    if (reg_re_o) ra_q.push_back(reg_addr_o);
    if (reg_we_o && reg_re_o) both_seen = 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic oe_any, output logic oe_all);
    rx = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sdi_i = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i]  = spi_sdo_o;
      oe_any = oe_any | spi_sdo_oe_o;
      oe_all = oe_all & spi_sdo_oe_o;
      spi_sck_i = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    logic       a, b;
    spi_bits(tx, 8, rx, a, b);
  endtask

  task automatic csb_low();
    spi_csb_i = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic csb_high();
    repeat (HALF) @(negedge clk);
    spi_csb_i = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); ra_q.delete();
  endtask

  function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 8'hxx;
  endfunction

  initial begin
    logic [7:0] rx;
    logic       oe_any, oe_all, oe_any_hdr, dummy;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h04;
    reg_rdata_i = 8'h00;
    spi_sck_i = 1'b0; spi_csb_i = 1'b1; spi_sdi_i = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_strobes_sdo_busy", {reg_we_o, reg_re_o, spi_sdo_o, spi_sdo_oe_o, busy_o}, 0);
    chk("rst_addr", reg_addr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1) single write
    clear_q();
    csb_low();
    chk("t1_busy", busy_o, 1);
    send(8'h80); send(8'h13); send(8'h66);
    csb_high();
    chk("t1_busy_after", busy_o, 0);
    chk("t1_nwrites", wa_q.size(), 1);
    chk("t1_addr", qget(wa_q, 0), 8'h13);
    chk("t1_data", qget(wd_q, 0), 8'h66);
    chk("t1_nreads", ra_q.size(), 0);

    // 2) streaming write
    clear_q();
    csb_low();
    send(8'h80); send(8'h13); send(8'h16); send(8'h06); send(8'h0e);
    csb_high();
    chk("t2_nwrites", wa_q.size(), 3);
    chk("t2_addr0", qget(wa_q, 0), 8'h13);
    chk("t2_data0", qget(wd_q, 0), 8'h16);
    chk("t2_addr1", qget(wa_q, 1), 8'h14);
    chk("t2_data1", qget(wd_q, 1), 8'h06);
    chk("t2_addr2", qget(wa_q, 2), 8'h15);
    chk("t2_data2", qget(wd_q, 2), 8'h0e);

    // 3) read of address 0 holding 0x04
    clear_q();
    csb_low();
    spi_bits(8'h40, 8, rx, oe_any_hdr, dummy);
    spi_bits(8'h00, 8, rx, oe_any, dummy);
    oe_any_hdr = oe_any_hdr | oe_any;
    chk("t3_oe_hdr", oe_any_hdr, 0);
    spi_bits(8'h00, 8, rx, oe_any, oe_all);
    chk("t3_sdo_byte", rx, 8'h04);
    chk("t3_oe_data", oe_all, 1);
    csb_high();
    chk("t3_oe_after", spi_sdo_oe_o, 0);
    chk("t3_nwrites", wa_q.size(), 0);
    chk("t3_read_addr0", qget(ra_q, 0), 8'h00);

    // 4) write with byte count 1
    clear_q();
    csb_low();
    send(8'h88); send(8'h10); send(8'hAA); send(8'h55);
    csb_high();
    chk("t4_nwrites", wa_q.size(), 1);
    chk("t4_addr", qget(wa_q, 0), 8'h10);
    chk("t4_data", qget(wd_q, 0), 8'hAA);

    // 5) address wrap
    clear_q();
    csb_low();
    send(8'h80); send(8'hFF); send(8'h11); send(8'h22);
    csb_high();
    chk("t5_nwrites", wa_q.size(), 2);
    chk("t5_addr0", qget(wa_q, 0), 8'hFF);
    chk("t5_data0", qget(wd_q, 0), 8'h11);
    chk("t5_addr1", qget(wa_q, 1), 8'h00);
    chk("t5_data1", qget(wd_q, 1), 8'h22);

    // 6a) CSB high after 5 data bits
    clear_q();
    csb_low();
    send(8'h80); send(8'h13);
    spi_bits(8'h66, 5, rx, oe_any, oe_all);
    csb_high();
    chk("t6a_nwrites", wa_q.size(), 0);

    // 6b) reset mid-address with CSB held low, then a full transfer without a new CSB fall
    clear_q();
    csb_low();
    send(8'h80);
    spi_bits(8'h13, 4, rx, oe_any, oe_all);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("t6b_addr_after_rst", reg_addr_o, 0);
    send(8'h80); send(8'h13); send(8'h66);
    csb_high();
    chk("t6b_nwrites", wa_q.size(), 0);
    chk("t6b_nreads", ra_q.size(), 0);

    // 6c) clean transfer afterwards
    clear_q();
    csb_low();
    send(8'h80); send(8'h13); send(8'h66);
    csb_high();
    chk("t6c_nwrites", wa_q.size(), 1);
    chk("t6c_addr", qget(wa_q, 0), 8'h13);
    chk("t6c_data", qget(wd_q, 0), 8'h66);

    chk("never_we_and_re", both_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
